// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and types for the one-hot-write register file.
// Contents : REGFILE_NUM_REGS / ADDR_W / DATA_W / ZERO_REG defaults,
//            reg_word_t (one register word), reg_addr_t (one read address).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_ADDR_W   = 5;
    localparam int REGFILE_DATA_W   = 64;
    localparam int REGFILE_ZERO_REG = 31;

    typedef logic [REGFILE_DATA_W-1:0] reg_word_t;
    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_onehot_wr_onehot_check.sv
`default_nettype none
// ============================================================================
// Module   : onehot_check
// Purpose  : Combinational classifier for a one-hot select vector.
// Ports    : sel       [N]      select vector under test
//            is_zero   [1]      no bit set
//            is_onehot [1]      exactly one bit set
//            is_multi  [1]      two or more bits set
//            idx       [IDX_W]  index of the set bit (valid when is_onehot)
// Revision : 1.0 - initial release
// ============================================================================
module onehot_check
    import regfile_pkg::*;
#(
    parameter int N     = REGFILE_NUM_REGS,
    parameter int IDX_W = REGFILE_ADDR_W
) (
    input  logic [N-1:0]     sel,
    output logic             is_zero,
    output logic             is_onehot,
    output logic             is_multi,
    output logic [IDX_W-1:0] idx
);

    logic             w_seen;
    logic             w_multi;
    logic [IDX_W-1:0] w_idx;

    // Single pass: a second set bit flags multi-hot. The index is built by
    // OR-ing the positions of set bits, which is exact when only one is set.
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
                w_idx  = w_idx | IDX_W'(i);
            end
        end
    end

    assign is_zero   = ~w_seen;
    assign is_onehot = w_seen & ~w_multi;
    assign is_multi  = w_multi;
    assign idx       = w_idx;

endmodule : onehot_check
`default_nettype wire

// File: rtl/regfile_onehot_wr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_onehot_wr
// Purpose  : Register file written through a one-hot select from the address
//            decoder tree, with two registered write-first read ports,
//            multi-hot select detection and a hardwired-zero register.
// Ports    : clk       [1]        rising-edge clock
//            reset     [1]        asynchronous active-high reset
//            wr_sel    [NUM_REGS] one-hot write select (all-zero = no write)
//            wr_data   [DATA_W]   write data
//            rd_addr1  [ADDR_W]   read port 1 address
//            rd_addr2  [ADDR_W]   read port 2 address
//            rd_data1  [DATA_W]   read port 1 data, 1-cycle latency
//            rd_data2  [DATA_W]   read port 2 data, 1-cycle latency
//            sel_err   [1]        pulse: previous edge saw a multi-hot select
//            err_count [8]        saturating count of multi-hot edges
// Revision : 1.0 - initial release
// ============================================================================
module regfile_onehot_wr
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ZERO_REG = REGFILE_ZERO_REG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                sel_err,
    output logic [7:0]          err_count
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);
    localparam logic [7:0]        c_err_max   = 8'hFF;

    logic              w_is_zero;
    logic              w_is_onehot;
    logic              w_is_multi;
    logic [ADDR_W-1:0] w_idx;
    logic              w_we;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic              r_sel_err;
    logic [7:0]        r_err_count;

    onehot_check #(
        .N     (NUM_REGS),
        .IDX_W (ADDR_W)
    ) u_onehot_check (
        .sel       (wr_sel),
        .is_zero   (w_is_zero),
        .is_onehot (w_is_onehot),
        .is_multi  (w_is_multi),
        .idx       (w_idx)
    );

    // A write happens only for a clean single-bit select that is not the
    // hardwired-zero slot; multi-hot selects write nothing at all.
    assign w_we = w_is_onehot && !w_is_zero && (w_idx != c_zero_addr);

    // ------------------------------------------------------------------
    // Storage. The zero slot holds no state so it can never leak data.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        if (gi == ZERO_REG) begin : g_zero
            assign r_regs[gi] = '0;
        end else begin : g_store
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_regs[gi] <= '0;
                end else if (w_we && (w_idx == ADDR_W'(gi))) begin
                    r_regs[gi] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read muxes with write-first bypass. The bypass is gated by w_we, so a
    // multi-hot edge returns the old contents of a selected address.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd1 = r_regs[rd_addr1];
        if (rd_addr1 == c_zero_addr) begin
            w_rd1 = '0;
        end else if (w_we && (w_idx == rd_addr1)) begin
            w_rd1 = wr_data;
        end
    end

    always_comb begin
        w_rd2 = r_regs[rd_addr2];
        if (rd_addr2 == c_zero_addr) begin
            w_rd2 = '0;
        end else if (w_we && (w_idx == rd_addr2)) begin
            w_rd2 = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read-output registers and error reporting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data1  <= '0;
            r_rd_data2  <= '0;
            r_sel_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_rd_data1 <= w_rd1;
            r_rd_data2 <= w_rd2;
            r_sel_err  <= w_is_multi;
            if (w_is_multi && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign rd_data1  = r_rd_data1;
    assign rd_data2  = r_rd_data2;
    assign sel_err   = r_sel_err;
    assign err_count = r_err_count;

endmodule : regfile_onehot_wr
`default_nettype wire

// File: tb/tb_regfile_onehot_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_onehot_wr
// Purpose  : Directed self-checking bench for regfile_onehot_wr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_onehot_wr;

    logic        clk;
    logic        reset;
    logic [31:0] wr_sel;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;
    logic        sel_err;
    logic [7:0]  err_count;

    int total;
    int bad;

    regfile_onehot_wr u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        wr_sel   = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        repeat (2) step();
        reset = 1'b0;

        check("reset_rd1", rd_data1, 64'h0);
        check("reset_rd2", rd_data2, 64'h0);
        check("reset_errcnt", {56'h0, err_count}, 64'h0);

        // Build up some state, then reset mid-cycle with a write pending.
        wr_sel = 32'h0000_0008; wr_data = 64'hDEAD_BEEF_0123_4567; rd_addr1 = 5'd3;
        step();
        check("pre_rst_bypass", rd_data1, 64'hDEAD_BEEF_0123_4567);
        wr_sel = 32'h0000_0006;
        step();
        check("pre_rst_errcnt", {56'h0, err_count}, 64'h1);
        wr_sel = 32'h0000_0080; wr_data = 64'h77;
        #2 reset = 1'b1;
        #1;
        check("midrst_rd1", rd_data1, 64'h0);
        check("midrst_selerr", {63'h0, sel_err}, 64'h0);
        check("midrst_errcnt", {56'h0, err_count}, 64'h0);
        wr_sel = '0;
        repeat (2) step();
        reset = 1'b0;

        // Every register must read zero after reset (reg 3 and pending reg 7 included).
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            step();
            check("postrst_rd1", rd_data1, 64'h0);
            check("postrst_rd2", rd_data2, 64'h0);
        end

        // Plain write then read next cycle.
        wr_sel = 32'h0000_0008; wr_data = 64'hDEAD_BEEF_0123_4567; rd_addr1 = 5'd0;
        step();
        wr_sel = '0; rd_addr1 = 5'd3;
        step();
        check("wr_rd_reg3", rd_data1, 64'hDEAD_BEEF_0123_4567);

        // Same-edge write with both ports reading the target.
        wr_sel = 32'h0000_0020; wr_data = 64'h55; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        step();
        check("bypass_rd1", rd_data1, 64'h55);
        check("bypass_rd2", rd_data2, 64'h55);

        // Write to the zero register is ignored and not an error.
        wr_sel = 32'h8000_0000; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr1 = 5'd31; rd_addr2 = 5'd3;
        step();
        check("zero_rd1", rd_data1, 64'h0);
        check("zero_selerr", {63'h0, sel_err}, 64'h0);
        check("zero_rd2_reg3", rd_data2, 64'hDEAD_BEEF_0123_4567);

        // Seed regs 1 and 2, then a multi-hot select covering both.
        wr_sel = 32'h0000_0002; wr_data = 64'h11;
        step();
        wr_sel = 32'h0000_0004; wr_data = 64'h22;
        step();
        wr_sel = 32'h0000_0006; wr_data = 64'h1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        step();
        check("multi_selerr", {63'h0, sel_err}, 64'h1);
        check("multi_errcnt", {56'h0, err_count}, 64'h1);
        check("multi_rd1_old", rd_data1, 64'h11);
        check("multi_rd2_old", rd_data2, 64'h22);
        wr_sel = '0;
        step();
        check("multi_pulse_end", {63'h0, sel_err}, 64'h0);
        check("multi_errcnt_hold", {56'h0, err_count}, 64'h1);
        check("multi_rd1_kept", rd_data1, 64'h11);
        check("multi_rd2_kept", rd_data2, 64'h22);

        // Saturation: 300 more multi-hot edges.
        wr_sel = 32'hFFFF_FFFF;
        repeat (300) step();
        check("sat_errcnt", {56'h0, err_count}, 64'hFF);
        check("sat_selerr", {63'h0, sel_err}, 64'h1);

        // Legal write to reg 0 after saturation.
        wr_sel = 32'h0000_0001; wr_data = 64'hABC; rd_addr1 = 5'd0; rd_addr2 = 5'd1;
        step();
        check("post_sat_selerr", {63'h0, sel_err}, 64'h0);
        check("post_sat_errcnt", {56'h0, err_count}, 64'hFF);
        check("post_sat_bypass", rd_data1, 64'hABC);
        check("post_sat_reg1", rd_data2, 64'h11);
        wr_sel = '0;
        step();
        check("post_sat_reg0", rd_data1, 64'hABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_onehot_wr
`default_nettype wire
